mux_10to1: RTL and testbench

- Registered 10-to-1 selector: picks one of ten input lanes by a 4-bit select and drives the chosen lane on a registered output.
- Flags out-of-range select codes.
- Leaf datapath block, used wherever a small clocked selection point is needed, e.g. routing one of several status or data lines to a shared consumer.

---
 rtl/mux_10to1.sv | 64 ++++++
 tb/tb_mux_10to1.sv | 114 +++++++++++
 2 files changed

// File: rtl/mux_10to1.sv
// Registered N_IN-to-1 lane selector with an out-of-range select flag.
// One cycle of latency. Synchronous active-high reset takes priority over the capture enable.
module mux_10to1 #(
  parameter int unsigned N_IN   = 10,
  parameter int unsigned DATA_W = 1,
  parameter int unsigned SEL_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [N_IN*DATA_W-1:0]   In,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        Out,
  output logic                     sel_err
);

  // Reject configurations that cannot be addressed or make no sense as a mux.
  if (N_IN < 2) begin : g_bad_min
    $error("mux_10to1: N_IN must be at least 2");
  end
  if (N_IN > (1 << SEL_W)) begin : g_bad_sel
    $error("mux_10to1: SEL_W too narrow to address N_IN lanes");
  end

  logic [DATA_W-1:0] out_q, out_d;
  logic              sel_err_q, sel_err_d;
  logic [DATA_W-1:0] lane_sel;
  logic              in_range;

  // Per-lane compare: only a code that matches a real lane marks the select as valid.
  always_comb begin
    lane_sel = '0;
    in_range = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        lane_sel = In[k*DATA_W +: DATA_W];
        in_range = 1'b1;
      end
    end
  end

  always_comb begin
    out_d     = out_q;
    sel_err_d = sel_err_q;
    if (en) begin
      out_d     = in_range ? lane_sel : '0;
      sel_err_d = ~in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign Out     = out_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_mux_10to1.sv
// Randomized and directed checks of mux_10to1 against a behavioural lane-pick model.
module tb_mux_10to1;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [9:0] In;
  logic [3:0] sel;
  logic [0:0] Out;
  logic       sel_err;

  int checks   = 0;
  int failures = 0;
  int exp_out  = 0;
  int exp_err  = 0;

  always #5 clk = ~clk;

  mux_10to1 #(
    .N_IN   (10),
    .DATA_W (1),
    .SEL_W  (4)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .In      (In),
    .sel     (sel),
    .Out     (Out),
    .sel_err (sel_err)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model on the edge, then compare.
  task automatic step(input logic r, input logic e, input int s, input int d, input string tag);
    @(negedge clk);
    rst = r;
    en  = e;
    sel = 4'(s);
    In  = 10'(d);
    @(posedge clk);
    if (r) begin
      exp_out = 0;
      exp_err = 0;
    end else if (e) begin
      if (s < 10) begin
        exp_out = (d >> s) & 1;
        exp_err = 0;
      end else begin
        exp_out = 0;
        exp_err = 1;
      end
    end
    #1;
    check_eq({tag, "_out"}, int'(Out), exp_out);
    check_eq({tag, "_err"}, int'(sel_err), exp_err);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    In  = 10'h3ff;
    sel = 4'd3;

    // Reset beats enable.
    step(1'b1, 1'b1, 3, 'h3ff, "reset");
    step(1'b1, 1'b1, 3, 'h3ff, "reset");
    check_eq("reset_out_const", int'(Out), 0);
    step(1'b0, 1'b1, 3, 'h3ff, "first_cap");
    check_eq("first_cap_const", int'(Out), 1);

    // Lane sweep with only lane 9 high.
    for (int s = 0; s < 10; s++) step(1'b0, 1'b1, s, 'h200, "sweep");

    // Walking one, matched and off-by-one select.
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, k, 1 << k, "walk_hit");
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, (k + 1) % 10, 1 << k, "walk_miss");

    // Counting input observed through lane 4.
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 4, i, "count");

    // Out-of-range codes, then recovery.
    for (int s = 10; s < 16; s++) step(1'b0, 1'b1, s, 'h3ff, "oor");
    check_eq("oor_err_const", int'(sel_err), 1);
    step(1'b0, 1'b1, 2, 'h3ff, "recover");
    check_eq("recover_err_const", int'(sel_err), 0);

    // Hold with en low, then reset while disabled.
    step(1'b0, 1'b1, 0, 'h001, "hold_load");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 12, 0, "hold");
    check_eq("hold_out_const", int'(Out), 1);
    step(1'b1, 1'b0, 12, 0, "rst_no_en");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           int'($urandom_range(0, 15)),
           int'($urandom_range(0, 1023)),
           "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
